// File: rtl/sudoku_board_ctrl.sv
// Purpose: 4x4 sudoku board controller with cursor navigation, cell entry and a sequential checker.
// Latency: button actions land on the next Clk edge; a check takes 12 cycles, one group per cycle.
// Backpressure: none; pulses arriving outside SOLVE (or beaten by a higher-priority pulse) are dropped.
//
// Ports:
//   Clk, Reset          - system clock, asynchronous active-high reset (reloads PUZZLE)
//   L, R, U, D, C       - single-cycle button pulses: move left/right/up/down, commit userIn
//   CheckSolu           - level switch; a rising edge in SOLVE starts a solution check
//   userIn[3:0]         - candidate value for the selected cell (0 clears, >4 rejected)
//   Cursor[3:0]         - selected cell index k = row*4 + col
//   CellVal[3:0]        - value of the selected cell
//   Grid[63:0]          - packed board, cell k at bits [4k+3:4k]
//   FailMask[11:0]      - failed groups: rows [3:0], columns [7:4], 2x2 boxes [11:8]
//   q_I .. q_Incorrect  - one-hot state flags
module sudoku_board_ctrl #(
    parameter logic [63:0] PUZZLE     = 64'h1034_0412_2140_4301,
    parameter logic [15:0] GIVEN_MASK = 16'hB7ED
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        L,
    input  logic        R,
    input  logic        U,
    input  logic        D,
    input  logic        C,
    input  logic        CheckSolu,
    input  logic [3:0]  userIn,
    output logic [3:0]  Cursor,
    output logic [3:0]  CellVal,
    output logic [63:0] Grid,
    output logic [11:0] FailMask,
    output logic        q_I,
    output logic        q_Solve,
    output logic        q_Check,
    output logic        q_Correct,
    output logic        q_Incorrect
);

    typedef enum logic [2:0] {
        S_I         = 3'd0,
        S_SOLVE     = 3'd1,
        S_CHECK     = 3'd2,
        S_CORRECT   = 3'd3,
        S_INCORRECT = 3'd4
    } state_t;

    state_t       state;
    state_t       state_nxt;

    logic [63:0]  board;
    logic [3:0]   cursor;
    logic [11:0]  fail_mask;
    logic [3:0]   grp;          // group under evaluation while in CHECK
    logic         cs_smp;       // registered CheckSolu
    logic         cs_prev;      // previous registered sample
    logic         check_edge;
    logic         grp_fail;
    logic         cell_writable;

    // Cell index of member j of group g. Rows are g=0..3, columns g=4..7,
    // boxes g=8..11; for a box b=g[1:0], row={b[1],j[1]} and col={b[0],j[0]}.
    function automatic logic [3:0] member_idx(input logic [3:0] g, input logic [1:0] j);
        logic [3:0] idx;
        if (g < 4'd4) begin
            idx = {g[1:0], j};
        end else if (g < 4'd8) begin
            idx = {j, g[1:0]};
        end else begin
            idx = {g[1], j[1], g[0], j[0]};
        end
        return idx;
    endfunction

    // A group passes only when every value 1..4 is seen; with four members
    // that is exactly a permutation. Values 0 or >4 contribute nothing.
    function automatic logic group_fails(input logic [63:0] b, input logic [3:0] g);
        logic [3:0] seen;
        logic [3:0] idx;
        logic [3:0] v;
        seen = 4'b0000;
        for (int j = 0; j < 4; j++) begin
            idx = member_idx(g, 2'(j));
            v   = b[{idx, 2'b00} +: 4];
            case (v)
                4'd1:    seen[0] = 1'b1;
                4'd2:    seen[1] = 1'b1;
                4'd3:    seen[2] = 1'b1;
                4'd4:    seen[3] = 1'b1;
                default: ;
            endcase
        end
        return seen != 4'b1111;
    endfunction

    assign check_edge    = cs_smp & ~cs_prev;
    assign grp_fail      = group_fails(board, grp);
    assign cell_writable = ~GIVEN_MASK[cursor] && (userIn <= 4'd4);

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_I;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_I: begin
                if (C) begin
                    state_nxt = S_SOLVE;
                end
            end
            S_SOLVE: begin
                if (check_edge) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (grp == 4'd11) begin
                    // The last group's verdict is not in fail_mask yet, so fold it in here.
                    if (fail_mask == 12'h000 && !grp_fail) begin
                        state_nxt = S_CORRECT;
                    end else begin
                        state_nxt = S_INCORRECT;
                    end
                end
            end
            S_CORRECT: begin
                state_nxt = S_CORRECT;
            end
            S_INCORRECT: begin
                if (!cs_smp) begin
                    state_nxt = S_SOLVE;
                end
            end
            default: begin
                state_nxt = S_I;
            end
        endcase
    end

    // Board, cursor, checker datapath
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            board     <= PUZZLE;
            cursor    <= 4'd0;
            fail_mask <= 12'h000;
            grp       <= 4'd0;
            cs_smp    <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            cs_smp  <= CheckSolu;
            cs_prev <= cs_smp;
            case (state)
                S_SOLVE: begin
                    if (check_edge) begin
                        fail_mask <= 12'h000;
                        grp       <= 4'd0;
                    end
                    // One button action per cycle; lower-priority pulses are dropped.
                    if (C) begin
                        if (cell_writable) begin
                            board[{cursor, 2'b00} +: 4] <= userIn;
                        end
                    end else if (L) begin
                        cursor <= {cursor[3:2], cursor[1:0] - 2'd1};
                    end else if (R) begin
                        cursor <= {cursor[3:2], cursor[1:0] + 2'd1};
                    end else if (U) begin
                        cursor <= {cursor[3:2] - 2'd1, cursor[1:0]};
                    end else if (D) begin
                        cursor <= {cursor[3:2] + 2'd1, cursor[1:0]};
                    end
                end
                S_CHECK: begin
                    if (grp_fail) begin
                        fail_mask[grp] <= 1'b1;
                    end
                    grp <= grp + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign Cursor      = cursor;
    assign CellVal     = board[{cursor, 2'b00} +: 4];
    assign Grid        = board;
    assign FailMask    = fail_mask;
    assign q_I         = (state == S_I);
    assign q_Solve     = (state == S_SOLVE);
    assign q_Check     = (state == S_CHECK);
    assign q_Correct   = (state == S_CORRECT);
    assign q_Incorrect = (state == S_INCORRECT);

endmodule

// File: tb/tb_sudoku_board_ctrl.sv
// Purpose: self-checking bench for sudoku_board_ctrl; vector table plus hand-written check sequences.
// Latency: each vector drives one cycle of inputs and compares the outputs one edge later.
// Backpressure: none; all waits on the DUT are bounded and count as failures on timeout.
module tb_sudoku_board_ctrl;

    localparam logic [63:0] PUZ = 64'h1034_0412_2140_4301;
    localparam logic [63:0] SOL = 64'h1234_3412_2143_4321;

    localparam logic [4:0] ST_I   = 5'b10000;
    localparam logic [4:0] ST_SLV = 5'b01000;
    localparam logic [4:0] ST_CHK = 5'b00100;
    localparam logic [4:0] ST_COR = 5'b00010;
    localparam logic [4:0] ST_INC = 5'b00001;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        L, R, U, D, C, CheckSolu;
    logic [3:0]  userIn;
    logic [3:0]  Cursor, CellVal;
    logic [63:0] Grid;
    logic [11:0] FailMask;
    logic        q_I, q_Solve, q_Check, q_Correct, q_Incorrect;

    sudoku_board_ctrl dut (
        .Clk(Clk), .Reset(Reset),
        .L(L), .R(R), .U(U), .D(D), .C(C),
        .CheckSolu(CheckSolu), .userIn(userIn),
        .Cursor(Cursor), .CellVal(CellVal), .Grid(Grid), .FailMask(FailMask),
        .q_I(q_I), .q_Solve(q_Solve), .q_Check(q_Check),
        .q_Correct(q_Correct), .q_Incorrect(q_Incorrect)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       l, r, u, d, c;
        logic [3:0] user;
        logic [4:0] st;
        logic [3:0] cur;
        logic [3:0] val;
    } vec_t;

    typedef struct {
        int         id;
        logic [4:0] st;
        logic [3:0] cur;
        logic [3:0] val;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [4:0] flags();
        return {q_I, q_Solve, q_Check, q_Correct, q_Incorrect};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", nm, act, expv);
        end
    endtask

    task automatic add(input logic l, r, u, d, c, input logic [3:0] user,
                       input logic [4:0] st, input logic [3:0] cur, input logic [3:0] val);
        vec_t v;
        v.l = l; v.r = r; v.u = u; v.d = d; v.c = c; v.user = user;
        v.st = st; v.cur = cur; v.val = val;
        vecs.push_back(v);
    endtask

    task automatic clear_btn();
        L = 1'b0; R = 1'b0; U = 1'b0; D = 1'b0; C = 1'b0;
    endtask

    // One cycle of button stimulus; called at a falling edge, returns at the next one.
    task automatic press(input logic l, r, u, d, c, input logic [3:0] user);
        L = l; R = r; U = u; D = d; C = c; userIn = user;
        @(posedge Clk); #1;
        clear_btn();
        @(negedge Clk);
    endtask

    // Waits (bounded) until the given state flags appear; timeout is a failed check.
    task automatic wait_state(input string nm, input logic [4:0] st, input int budget);
        int n;
        n = 0;
        while (flags() !== st && n < budget) begin
            @(posedge Clk); #1;
            n++;
        end
        chk(nm, {59'd0, flags()}, {59'd0, st});
    endtask

    // Counts consecutive cycles with q_Check high, starting from its first appearance.
    task automatic measure_check(input string nm, output int cycles);
        int n;
        n = 0;
        while (!q_Check && n < 8) begin
            @(posedge Clk); #1;
            n++;
        end
        cycles = 0;
        if (q_Check) begin
            chk({nm, "_entry_failmask"}, {52'd0, FailMask}, 64'd0);
            while (q_Check && cycles < 40) begin
                cycles++;
                @(posedge Clk); #1;
            end
        end
        chk({nm, "_check_cycles"}, 64'(cycles), 64'd12);
    endtask

    initial begin
        int   ccount;
        exp_t e;

        Reset = 1'b1; CheckSolu = 1'b0; userIn = 4'd0;
        clear_btn();

        // Table: inputs for one cycle, then expected flags/Cursor/CellVal after the edge.
        //   l  r  u  d  c  user   state   cur    val
        add(0, 0, 0, 0, 0, 4'd0, ST_I,   4'd0,  4'd1);  // idle stays in I
        add(1, 1, 1, 1, 0, 4'd3, ST_I,   4'd0,  4'd1);  // moves ignored in I
        add(0, 0, 0, 0, 1, 4'd0, ST_SLV, 4'd0,  4'd1);  // C enters SOLVE, no write
        add(0, 1, 0, 0, 0, 4'd0, ST_SLV, 4'd1,  4'd0);
        add(0, 0, 0, 0, 1, 4'd2, ST_SLV, 4'd1,  4'd2);  // write blank cell 1
        add(1, 0, 0, 0, 0, 4'd0, ST_SLV, 4'd0,  4'd1);
        add(0, 0, 0, 0, 1, 4'd4, ST_SLV, 4'd0,  4'd1);  // given cell locked
        add(0, 1, 0, 0, 0, 4'd0, ST_SLV, 4'd1,  4'd2);
        add(0, 0, 0, 0, 1, 4'd7, ST_SLV, 4'd1,  4'd2);  // out-of-range value rejected
        add(1, 0, 0, 0, 0, 4'd0, ST_SLV, 4'd0,  4'd1);
        add(1, 0, 0, 0, 0, 4'd0, ST_SLV, 4'd3,  4'd4);  // L wraps col 0 -> 3
        add(0, 0, 1, 0, 0, 4'd0, ST_SLV, 4'd15, 4'd1);  // U wraps row 0 -> 3
        add(0, 0, 0, 1, 0, 4'd0, ST_SLV, 4'd3,  4'd4);  // D wraps row 3 -> 0
        add(0, 1, 0, 0, 0, 4'd0, ST_SLV, 4'd0,  4'd1);  // R wraps col 3 -> 0
        add(0, 0, 0, 1, 0, 4'd0, ST_SLV, 4'd4,  4'd0);
        add(1, 0, 0, 0, 1, 4'd3, ST_SLV, 4'd4,  4'd3);  // C beats L
        add(0, 1, 1, 1, 0, 4'd0, ST_SLV, 4'd5,  4'd4);  // R beats U, D
        add(1, 0, 0, 0, 0, 4'd0, ST_SLV, 4'd4,  4'd3);
        add(0, 0, 0, 1, 0, 4'd0, ST_SLV, 4'd8,  4'd2);
        add(0, 1, 0, 0, 0, 4'd0, ST_SLV, 4'd9,  4'd1);
        add(0, 1, 0, 0, 0, 4'd0, ST_SLV, 4'd10, 4'd4);
        add(0, 1, 0, 0, 0, 4'd0, ST_SLV, 4'd11, 4'd0);
        add(0, 0, 0, 0, 1, 4'd3, ST_SLV, 4'd11, 4'd3);
        add(0, 0, 0, 1, 0, 4'd0, ST_SLV, 4'd15, 4'd1);
        add(1, 0, 0, 0, 0, 4'd0, ST_SLV, 4'd14, 4'd0);
        add(0, 0, 1, 1, 0, 4'd0, ST_SLV, 4'd10, 4'd4);  // U beats D
        add(0, 0, 0, 1, 0, 4'd0, ST_SLV, 4'd14, 4'd0);
        add(0, 0, 0, 0, 1, 4'd5, ST_SLV, 4'd14, 4'd0);  // value 5 rejected

        // Reset state
        repeat (2) @(negedge Clk);
        chk("reset_flags_during", {59'd0, flags()}, {59'd0, ST_I});
        Reset = 1'b0;
        @(negedge Clk);
        chk("reset_flags", {59'd0, flags()}, {59'd0, ST_I});
        chk("reset_cursor", {60'd0, Cursor}, 64'd0);
        chk("reset_grid", Grid, PUZ);
        chk("reset_failmask", {52'd0, FailMask}, 64'd0);

        // Table-driven cycles through a scoreboard
        for (int i = 0; i < vecs.size(); i++) begin
            L = vecs[i].l; R = vecs[i].r; U = vecs[i].u; D = vecs[i].d; C = vecs[i].c;
            userIn = vecs[i].user;
            e.id = i; e.st = vecs[i].st; e.cur = vecs[i].cur; e.val = vecs[i].val;
            sb.push_back(e);
            @(posedge Clk); #1;
            clear_btn();
            e = sb.pop_front();
            chk($sformatf("vec%0d_flags", e.id), {59'd0, flags()}, {59'd0, e.st});
            chk($sformatf("vec%0d_cursor", e.id), {60'd0, Cursor}, {60'd0, e.cur});
            chk($sformatf("vec%0d_cellval", e.id), {60'd0, CellVal}, {60'd0, e.val});
            @(negedge Clk);
        end
        chk("table_grid", Grid, SOL & ~(64'hF << 56));

        // Check with cell 14 still blank: row 3, column 2, box 3 fail.
        CheckSolu = 1'b1;
        measure_check("inc", ccount);
        chk("inc_flags", {59'd0, flags()}, {59'd0, ST_INC});
        chk("inc_failmask", {52'd0, FailMask}, 64'h848);
        @(negedge Clk);
        press(0, 0, 0, 0, 1, 4'd2);                      // ignored outside SOLVE
        chk("inc_grid_frozen", Grid, SOL & ~(64'hF << 56));
        CheckSolu = 1'b0;
        @(posedge Clk); #1;
        chk("inc_hold_one_cycle", {59'd0, flags()}, {59'd0, ST_INC});
        @(posedge Clk); #1;
        chk("inc_to_solve", {59'd0, flags()}, {59'd0, ST_SLV});
        chk("inc_failmask_kept", {52'd0, FailMask}, 64'h848);
        @(negedge Clk);

        // Complete the board and check again.
        press(0, 0, 0, 0, 1, 4'd2);
        chk("full_grid", Grid, SOL);
        CheckSolu = 1'b1;
        measure_check("cor", ccount);
        chk("cor_flags", {59'd0, flags()}, {59'd0, ST_COR});
        chk("cor_failmask", {52'd0, FailMask}, 64'd0);
        @(negedge Clk);
        for (int i = 0; i < 6; i++) begin
            CheckSolu = ~CheckSolu;
            press(1, 0, 0, 0, 1, 4'd1);
        end
        chk("cor_terminal", {59'd0, flags()}, {59'd0, ST_COR});
        chk("cor_grid_frozen", Grid, SOL);
        chk("cor_cursor_frozen", {60'd0, Cursor}, 64'd14);

        // Reset in the middle of a check.
        CheckSolu = 1'b0;
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        press(0, 0, 0, 0, 1, 4'd0);
        press(0, 1, 0, 0, 0, 4'd0);
        press(0, 0, 0, 0, 1, 4'd2);
        chk("mid_grid_modified", Grid, PUZ | (64'h2 << 4));
        CheckSolu = 1'b1;
        wait_state("mid_enter_check", ST_CHK, 8);
        repeat (4) @(posedge Clk);
        #2;
        chk("mid_failmask_nonzero", {63'd0, (FailMask != 12'h000)}, 64'd1);
        Reset = 1'b1;
        #1;
        chk("mid_reset_flags", {59'd0, flags()}, {59'd0, ST_I});
        chk("mid_reset_grid", Grid, PUZ);
        chk("mid_reset_failmask", {52'd0, FailMask}, 64'd0);
        chk("mid_reset_cursor", {60'd0, Cursor}, 64'd0);
        @(negedge Clk);
        Reset = 1'b0;
        CheckSolu = 1'b0;
        @(negedge Clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sudoku_board_ctrl.md
SUDOKU_BOARD_CTRL -- requirements
Module: sudoku_board_ctrl

Interface
REQ-001 Parameter PUZZLE, 64-bit, default: solution grid 1234/3412/2143/4321 with cells 1, 4, 11, 14 set to 0; initial cell values, cell k at bits [4k+3:4k], k = row*4+col.
REQ-002 Parameter GIVEN_MASK, 16-bit, default 16'hB7ED; bit k = 1 marks cell k as a locked given.
REQ-003 Clk  input  1  single system clock, all state on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high; clears/reloads all state immediately.
REQ-005 L, R, U, D, C  input  1 each  single-cycle button pulses: move left/right/up/down, commit.
REQ-006 CheckSolu  input  1  level switch; a rising edge requests a solution check.
REQ-007 userIn  input  4  candidate cell value.
REQ-008 Cursor  output  4  selected cell index k.
REQ-009 CellVal  output  4  current value of cell Cursor.
REQ-010 Grid  output  64  packed board, same layout as PUZZLE.
REQ-011 FailMask  output  12  per-group check failure: bits 0-3 rows, 4-7 columns, 8-11 2x2 boxes (box b: rows 2*(b/2)..+1, cols 2*(b%2)..+1).
REQ-012 q_I, q_Solve, q_Check, q_Correct, q_Incorrect  output  1 each  one-hot state flags.

Function
REQ-013 States I, SOLVE, CHECK, CORRECT, INCORRECT; exactly one q_* flag high at all times.
REQ-014 I: C pulse -> SOLVE next cycle; all other inputs ignored.
REQ-015 SOLVE: at most one action per cycle, priority C > L > R > U > D; lower-priority simultaneous pulses are dropped.
REQ-016 Moves wrap within row/column: L at col 0 -> col 3, R at col 3 -> col 0, U at row 0 -> row 3, D at row 3 -> row 0; Cursor updates on the next edge.
REQ-017 C in SOLVE: if GIVEN_MASK[Cursor]=0 and userIn <= 4, cell Cursor <= userIn next edge (0 clears); otherwise no change.
REQ-018 CheckSolu is registered once; rising edge = sampled 1 with previous sample 0; edge in SOLVE -> CHECK next cycle, FailMask cleared on CHECK entry; edges in other states ignored.
REQ-019 CHECK evaluates one group per cycle, index 0..11, exactly 12 cycles; group fails unless its four values are a permutation of 1..4 (seen-value bitmask = 4'b1111); FailMask[g] set on failure.
REQ-020 After group 11 -> CORRECT if all groups passed, else INCORRECT; FailMask holds final result.
REQ-021 Button pulses and userIn ignored in CHECK, CORRECT, INCORRECT; Grid and Cursor frozen.
REQ-022 CORRECT is terminal until Reset.
REQ-023 INCORRECT -> SOLVE on the cycle after CheckSolu sample = 0; FailMask retained until next CHECK entry.
REQ-024 CellVal and Grid are combinational views of board registers; no extra latency.

Reset
REQ-025 Reset asserted: state I, Cursor 0, Grid = PUZZLE, FailMask 0, CheckSolu edge register 0, regardless of state (including mid-CHECK).
REQ-026 Reset deasserted: first action possible on the first rising Clk edge after release.

Verification
REQ-027 Reset -> q_I=1, Cursor=0, Grid=PUZZLE, FailMask=12'h000; L/R/U/D/C-free idle keeps q_I.
REQ-028 C -> q_Solve; R -> Cursor=1; userIn=2, C -> CellVal=2; L -> Cursor=0; userIn=4, C -> CellVal stays 1 (given); userIn=7 at cell 1, C -> stays 2.
REQ-029 Cursor 0: L -> 3, U -> 15, D -> 3; L and C same cycle at blank cell 4 writes cell 4, Cursor unchanged.
REQ-030 Write 2,3,3,2 into cells 1,4,11,14; raise CheckSolu -> q_Check high exactly 12 cycles, then q_Correct, FailMask=12'h000; later toggling ignored.
REQ-031 Cells 1,4,11 correct, cell 14 left 0; check -> q_Incorrect, FailMask=12'h848; drop CheckSolu -> q_Solve next cycle after sample.
REQ-032 Assert Reset during cycle 5 of CHECK -> q_I, Grid=PUZZLE, FailMask=0 immediately.
